// File: rtl/fifo_fwft.sv
// -----------------------------------------------------------------------------
// fifo_fwft
//
// Single-clock first-word-fall-through FIFO. The head of the queue is always
// shown on dout, qualified by empty=0; asserting rd_en pops it. Storage is a
// synchronous-read RAM of 2**DEPTH_WIDTH words plus one output (prefetch)
// register, giving a total capacity of 2**DEPTH_WIDTH + 1 words.
//
// Ports:
//   clk    in   clock, all state updates on the rising edge
//   rst    in   synchronous active-high reset (pointers, valid, dout)
//   din    in   write data, sampled when wr_en=1 and full=0
//   wr_en  in   write strobe
//   full   out  RAM holds 2**DEPTH_WIDTH words; writes are dropped
//   dout   out  head-of-queue word, meaningful when empty=0
//   rd_en  in   pop strobe, honoured when empty=0
//   empty  out  no valid word on dout
// -----------------------------------------------------------------------------
module fifo_fwft #(
    parameter int DEPTH_WIDTH = 4,
    parameter int DATA_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  wr_en,
    output logic                  full,
    output logic [DATA_WIDTH-1:0] dout,
    input  logic                  rd_en,
    output logic                  empty
);

    localparam int DEPTH = 1 << DEPTH_WIDTH;
    localparam logic [DEPTH_WIDTH:0] PTR_ONE = {{DEPTH_WIDTH{1'b0}}, 1'b1};

    logic [DATA_WIDTH-1:0]  mem_q [DEPTH];

    logic [DEPTH_WIDTH:0]   wptr_q, wptr_d;
    logic [DEPTH_WIDTH:0]   wptr_vis_q;
    logic [DEPTH_WIDTH:0]   rptr_q, rptr_d;
    logic                   valid_q, valid_d;
    logic [DATA_WIDTH-1:0]  dout_q, dout_d;

    logic                   wr_fire;
    logic                   pop;
    logic                   ram_empty;
    logic                   prefetch;

    // Full compares the live write pointer: same slot index, opposite lap.
    assign full  = (wptr_q[DEPTH_WIDTH] != rptr_q[DEPTH_WIDTH]) &&
                   (wptr_q[DEPTH_WIDTH-1:0] == rptr_q[DEPTH_WIDTH-1:0]);
    assign empty = !valid_q;
    assign dout  = dout_q;

    assign wr_fire = wr_en && !full;
    assign pop     = rd_en && valid_q;

    // The read side sees the write pointer one cycle late, so a word becomes
    // readable only on the edge after it was stored. This keeps the RAM from
    // ever having to resolve a read and a write of the same slot on one edge,
    // and gives the two-edge first-word latency.
    assign ram_empty = (wptr_vis_q == rptr_q);

    // Refill the output register when it is vacant or being popped this edge;
    // popping and refilling on the same edge keeps the read stream bubble-free.
    assign prefetch = !ram_empty && (!valid_q || pop);

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        valid_d = valid_q;
        dout_d  = dout_q;
        if (wr_fire) begin
            wptr_d = wptr_q + PTR_ONE;
        end
        if (prefetch) begin
            rptr_d  = rptr_q + PTR_ONE;
            dout_d  = mem_q[rptr_q[DEPTH_WIDTH-1:0]];
            valid_d = 1'b1;
        end else if (pop) begin
            // Popped with nothing readable behind it; dout keeps its old value.
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q     <= '0;
            wptr_vis_q <= '0;
            rptr_q     <= '0;
            valid_q    <= 1'b0;
            dout_q     <= '0;
        end else begin
            wptr_q     <= wptr_d;
            wptr_vis_q <= wptr_q;
            rptr_q     <= rptr_d;
            valid_q    <= valid_d;
            dout_q     <= dout_d;
        end
    end

    // RAM array is deliberately not reset; stale contents are unreachable
    // once the pointers are cleared.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem_q[wptr_q[DEPTH_WIDTH-1:0]] <= din;
        end
    end

endmodule

// File: tb/tb_fifo_fwft.sv
// -----------------------------------------------------------------------------
// tb_fifo_fwft
//
// Directed bench for fifo_fwft with default parameters (16-word RAM, 16-bit
// data, 17-word total capacity). Inputs change 1 time unit after a rising
// edge; outputs are checked at that same point, i.e. they reflect the state
// left by the edge just taken.
// -----------------------------------------------------------------------------
module tb_fifo_fwft;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] din;
    logic        wr_en;
    logic        full;
    logic [15:0] dout;
    logic        rd_en;
    logic        empty;

    int errors = 0;
    int checks = 0;

    logic [15:0] exp_q [$];
    logic [15:0] stim [128];

    fifo_fwft #(
        .DEPTH_WIDTH(4),
        .DATA_WIDTH (16)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .din  (din),
        .wr_en(wr_en),
        .full (full),
        .dout (dout),
        .rd_en(rd_en),
        .empty(empty)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Run one random-rate transfer of 128 words and compare every popped word.
    task automatic stress(input int wr_pct, input int rd_pct);
        int wr_idx;
        int rd_idx;
        int cyc;
        logic do_wr;
        logic do_rd;
        wr_idx = 0;
        rd_idx = 0;
        cyc    = 0;
        for (int i = 0; i < 128; i++) stim[i] = 16'($urandom);
        while (rd_idx < 128 && cyc < 10000) begin
            do_wr = (wr_idx < 128) && ($urandom_range(99) < wr_pct);
            do_rd = ($urandom_range(99) < rd_pct);
            wr_en = do_wr;
            din   = (wr_idx < 128) ? stim[wr_idx] : 16'h0000;
            rd_en = do_rd;
            if (do_rd && !empty) begin
                chk("stress_data", dout, stim[rd_idx]);
                rd_idx++;
            end
            if (do_wr && !full) wr_idx++;
            tick();
            cyc++;
        end
        wr_en = 1'b0;
        rd_en = 1'b0;
        chk("stress_count", rd_idx, 128);
        chk("stress_empty", empty, 1'b1);
    endtask

    initial begin
        rst   = 1'b1;
        din   = 16'h1234;
        wr_en = 1'b1;
        rd_en = 1'b1;

        // Reset held with both strobes active
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("rst_empty", empty, 1'b1);
            chk("rst_full", full, 1'b0);
            chk("rst_dout", dout, 16'h0000);
        end
        rst   = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("idle_empty", empty, 1'b1);
        end

        // First-word latency: write at edge k, visible after edge k+2
        din   = 16'hA5A5;
        wr_en = 1'b1;
        tick();
        wr_en = 1'b0;
        chk("lat_k_empty", empty, 1'b1);
        tick();
        chk("lat_k1_empty", empty, 1'b1);
        tick();
        chk("lat_k2_empty", empty, 1'b0);
        chk("lat_k2_dout", dout, 16'hA5A5);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk("lat_pop_empty", empty, 1'b1);
        chk("lat_pop_hold", dout, 16'hA5A5);

        // Fill with 17 words; full only after the 17th
        for (int i = 0; i <= 16; i++) begin
            din   = 16'(i);
            wr_en = 1'b1;
            tick();
            chk("fill_full", full, (i == 16) ? 1'b1 : 1'b0);
        end
        din = 16'hFFFF;
        tick();
        wr_en = 1'b0;
        chk("fill_drop_full", full, 1'b1);
        for (int i = 0; i <= 16; i++) begin
            chk("drain_empty", empty, 1'b0);
            chk("drain_dout", dout, 16'(i));
            rd_en = 1'b1;
            tick();
        end
        rd_en = 1'b0;
        chk("drain_done_empty", empty, 1'b1);
        chk("drain_done_full", full, 1'b0);

        // Simultaneous read/write while full
        for (int i = 0; i <= 16; i++) begin
            din   = 16'h0100 + 16'(i);
            wr_en = 1'b1;
            tick();
        end
        chk("rw_full_before", full, 1'b1);
        din   = 16'hDEAD;
        wr_en = 1'b1;
        rd_en = 1'b1;
        tick();
        wr_en = 1'b0;
        rd_en = 1'b0;
        chk("rw_full_after", full, 1'b0);
        chk("rw_head", dout, 16'h0101);
        din   = 16'hBEEF;
        wr_en = 1'b1;
        tick();
        wr_en = 1'b0;
        chk("rw_refull", full, 1'b1);
        exp_q.delete();
        for (int i = 1; i <= 16; i++) exp_q.push_back(16'h0100 + 16'(i));
        exp_q.push_back(16'hBEEF);
        for (int i = 0; i < 17; i++) begin
            chk("rw_drain_empty", empty, 1'b0);
            chk("rw_drain_dout", dout, exp_q[i]);
            rd_en = 1'b1;
            tick();
        end
        rd_en = 1'b0;
        chk("rw_done_empty", empty, 1'b1);

        // Wrap-around stress at three rate mixes
        stress(30, 90);
        stress(90, 30);
        stress(100, 100);

        // Reads on an empty FIFO are ignored
        rd_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("er_empty", empty, 1'b1);
        end
        rd_en = 1'b0;
        din   = 16'h5A5A;
        wr_en = 1'b1;
        tick();
        wr_en = 1'b0;
        tick();
        tick();
        chk("er_word_empty", empty, 1'b0);
        chk("er_word_dout", dout, 16'h5A5A);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk("er_after_empty", empty, 1'b1);
        // Capacity still exactly 17 words, so the pointers stayed consistent
        for (int i = 0; i <= 16; i++) begin
            din   = 16'h7000 + 16'(i);
            wr_en = 1'b1;
            tick();
            chk("er_cap_full", full, (i == 16) ? 1'b1 : 1'b0);
        end
        wr_en = 1'b0;
        chk("er_cap_head", dout, 16'h7000);

        // Reset in the middle of a full FIFO discards everything
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_empty", empty, 1'b1);
        chk("mid_rst_full", full, 1'b0);
        chk("mid_rst_dout", dout, 16'h0000);
        tick();
        tick();
        chk("mid_rst_stay_empty", empty, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
